// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register-file completer.
package apb_regfile_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_WO  = 2'd2,
    ACC_W1C = 2'd3
  } acc_t;

  // Overlapping mask bits resolve as RO > W1C > WO > RW.
  function automatic acc_t acc_decode(input logic ro, input logic w1c, input logic wo);
    acc_t acc;
    if (ro) begin
      acc = ACC_RO;
    end else if (w1c) begin
      acc = ACC_W1C;
    end else if (wo) begin
      acc = ACC_WO;
    end else begin
      acc = ACC_RW;
    end
    return acc;
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One register of the file: byte-strobed write, or W1C clear with hardware set.
module apb_reg_cell
  import apb_regfile_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter acc_t        ACC = ACC_RW
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            i_we,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic [DW-1:0]   i_set,
  output logic [DW-1:0]   o_q
);

  localparam int unsigned SW = DW / 8;

  logic [DW-1:0] r_q;
  logic [DW-1:0] w_q_nxt;
  logic [DW-1:0] w_bmask;

  // Next value; for W1C the hardware set is applied last so it wins over a clear.
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < SW; b++) begin
      w_bmask[8*b +: 8] = {8{i_wstrb[b]}};
    end
    w_q_nxt = r_q;
    case (ACC)
      ACC_RO: begin
        w_q_nxt = '0;
      end
      ACC_W1C: begin
        if (i_we) begin
          w_q_nxt = r_q & ~(i_wdata & w_bmask);
        end
        w_q_nxt = w_q_nxt | i_set;
      end
      default: begin
        if (i_we) begin
          w_q_nxt = (r_q & ~w_bmask) | (i_wdata & w_bmask);
        end
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer over N_REG registers with per-register RW/RO/WO/W1C access,
// programmable wait states and decode/protection errors on PSLVERR.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int unsigned      DW       = 32,
  parameter int unsigned      AW       = 8,
  parameter int unsigned      N_REG    = 8,
  parameter int unsigned      RD_WAIT  = 1,
  parameter int unsigned      WR_WAIT  = 0,
  parameter logic [N_REG-1:0] RO_MASK  = '0,
  parameter logic [N_REG-1:0] WO_MASK  = '0,
  parameter logic [N_REG-1:0] W1C_MASK = '0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [AW-1:0]       i_paddr,
  input  logic                i_pwrite,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic [DW-1:0]       i_pwdata,
  input  logic [DW/8-1:0]     i_pstrb,
  output logic [DW-1:0]       o_prdata,
  output logic                o_pready,
  output logic                o_pslverr,
  output logic [N_REG*DW-1:0] o_hw_ctl,
  input  logic [N_REG*DW-1:0] i_hw_sts,
  input  logic [N_REG*DW-1:0] i_hw_set,
  output logic [N_REG-1:0]    o_wr_pulse
);

  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(SW);
  localparam int unsigned IW       = AW - ADDR_LSB;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IW-1:0]    r_idx;
  logic             r_write;
  logic             r_err;
  logic [N_REG-1:0] r_wr_pulse;

  logic [IW-1:0]    w_idx;
  logic             w_misalign;
  logic             w_in_range;
  logic             w_sel_ro;
  logic             w_sel_wo;
  logic             w_err;
  logic             w_setup;
  logic             w_ready;
  logic             w_commit;
  logic [N_REG-1:0] w_ro;
  logic [N_REG-1:0] w_wo;
  logic [N_REG-1:0] w_we;
  logic [DW-1:0]    w_rd_sel;
  logic [DW-1:0]    w_q [N_REG];

  assign w_idx = i_paddr[AW-1:ADDR_LSB];

  if (ADDR_LSB > 0) begin : g_lsb
    assign w_misalign = |i_paddr[ADDR_LSB-1:0];
  end else begin : g_nolsb
    assign w_misalign = 1'b0;
  end

  // Register cells with their resolved access mode.
  for (genvar i = 0; i < N_REG; i++) begin : g_reg
    localparam acc_t ACC = acc_decode(RO_MASK[i], W1C_MASK[i], WO_MASK[i]);

    assign w_ro[i] = (ACC == ACC_RO);
    assign w_wo[i] = (ACC == ACC_WO);
    assign w_we[i] = w_commit && (r_idx == IW'(i));

    apb_reg_cell #(
      .DW  (DW),
      .ACC (ACC)
    ) u_cell (
      .pclk    (pclk),
      .preset  (preset),
      .i_we    (w_we[i]),
      .i_wdata (i_pwdata),
      .i_wstrb (i_pstrb),
      .i_set   (i_hw_set[i*DW +: DW]),
      .o_q     (w_q[i])
    );

    assign o_hw_ctl[i*DW +: DW] = w_q[i];
  end

  // Setup-phase error decode: out of range, misaligned, or access-mode violation.
  always_comb begin
    w_in_range = 1'b0;
    w_sel_ro   = 1'b0;
    w_sel_wo   = 1'b0;
    for (int i = 0; i < N_REG; i++) begin
      if (w_idx == IW'(i)) begin
        w_in_range = 1'b1;
        w_sel_ro   = w_ro[i];
        w_sel_wo   = w_wo[i];
      end
    end
    w_err = ~w_in_range | w_misalign | (i_pwrite & w_sel_ro) | (~i_pwrite & w_sel_wo);
  end

  // Read source: live hardware status for RO registers, stored value otherwise.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (r_idx == IW'(i)) begin
        w_rd_sel = w_ro[i] ? i_hw_sts[i*DW +: DW] : w_q[i];
      end
    end
  end

  // Transfer FSM: the wait counter only ever counts down from a nonzero value.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_setup     = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_psel && !i_penable) begin
          w_setup     = 1'b1;
          w_cnt_nxt   = i_pwrite ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (i_penable) begin
          w_ready     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_commit = w_ready & r_write & ~r_err;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_wr_pulse <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wr_pulse <= w_we;
      if (w_setup) begin
        r_idx   <= w_idx;
        r_write <= i_pwrite;
        r_err   <= w_err;
      end
    end
  end

  assign o_pready   = w_ready;
  assign o_pslverr  = w_ready & r_err;
  assign o_prdata   = (w_ready & ~r_err & ~r_write) ? w_rd_sel : '0;
  assign o_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: two instances differing only in write wait states.
module tb_apb_regfile_slave;

  localparam int unsigned N = 8;

  logic           pclk;
  logic           preset;
  logic [7:0]     paddr;
  logic           pwrite;
  logic           psel;
  logic           penable;
  logic [31:0]    pwdata;
  logic [3:0]     pstrb;
  logic [N*32-1:0] hw_sts;
  logic [N*32-1:0] hw_set;

  logic [31:0]     prdata0, prdata1;
  logic            pready0, pready1;
  logic            pslverr0, pslverr1;
  logic [N*32-1:0] hw_ctl0, hw_ctl1;
  logic [N-1:0]    wr_pulse0, wr_pulse1;

  int checks = 0;
  int errors = 0;

  apb_regfile_slave #(
    .DW(32), .AW(8), .N_REG(N), .RD_WAIT(1), .WR_WAIT(0),
    .RO_MASK(8'b0000_1000), .WO_MASK(8'b0000_0010), .W1C_MASK(8'b0000_0100)
  ) u_dut0 (
    .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite), .i_psel(psel),
    .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb), .o_prdata(prdata0),
    .o_pready(pready0), .o_pslverr(pslverr0), .o_hw_ctl(hw_ctl0), .i_hw_sts(hw_sts),
    .i_hw_set(hw_set), .o_wr_pulse(wr_pulse0)
  );

  apb_regfile_slave #(
    .DW(32), .AW(8), .N_REG(N), .RD_WAIT(1), .WR_WAIT(3),
    .RO_MASK(8'b0000_1000), .WO_MASK(8'b0000_0010), .W1C_MASK(8'b0000_0100)
  ) u_dut1 (
    .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite), .i_psel(psel),
    .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb), .o_prdata(prdata1),
    .o_pready(pready1), .o_pslverr(pslverr1), .o_hw_ctl(hw_ctl1), .i_hw_sts(hw_sts),
    .i_hw_set(hw_set), .o_wr_pulse(wr_pulse1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [N*32-1:0] obs,
                            input logic [N*32-1:0] exp);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s[%0d]", tag, i), obs[i*32 +: 32], exp[i*32 +: 32]);
    end
  endtask

  // Full APB transfer; returns cycles from setup to completion, read data and error.
  task automatic apb_xfer(input int dut, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output int cyc, output logic [31:0] rdata, output logic err);
    bit   done;
    logic rdy;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    cyc = 1; done = 1'b0; rdata = '0; err = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 2;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk);
      rdy = (dut == 0) ? pready0 : pready1;
      if (rdy) begin
        rdata = (dut == 0) ? prdata0 : prdata1;
        err   = (dut == 0) ? pslverr0 : pslverr1;
        done  = 1'b1;
      end
      @(posedge pclk); #1;
      if (!done) cyc++;
    end
    psel = 1'b0; penable = 1'b0;
    check("xfer_completed", 32'(done), 32'd1);
  endtask

  initial begin
    int              cyc;
    logic [31:0]     rd;
    logic            err;
    logic [N*32-1:0] exp0;

    preset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    hw_sts = {N{32'hA5A5_A5A5}};
    hw_sts[3*32 +: 32] = 32'hDEAD_BEEF;
    hw_set = '0;
    exp0 = '0;

    #1;
    check("rst_pready", 32'(pready0), 32'd0);
    check("rst_pslverr", 32'(pslverr0), 32'd0);
    check("rst_prdata", prdata0, 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse0), 32'd0);
    check_regs("rst_hw_ctl", hw_ctl0, exp0);
    #21 preset = 1'b0;

    // RW write with strobes 0101, then read back
    apb_xfer(0, 1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101, cyc, rd, err);
    check("wr0_cycles", 32'(cyc), 32'd2);
    check("wr0_err", 32'(err), 32'd0);
    check("wr0_ctl", hw_ctl0[31:0], 32'h00BB_00DD);
    check("wr0_pulse", 32'(wr_pulse0), 32'h01);
    @(posedge pclk); #1;
    check("wr0_pulse_off", 32'(wr_pulse0), 32'h00);
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, cyc, rd, err);
    check("rd0_cycles", 32'(cyc), 32'd3);
    check("rd0_data", rd, 32'h00BB_00DD);
    check("rd0_err", 32'(err), 32'd0);
    exp0[0*32 +: 32] = 32'h00BB_00DD;

    // Protection: RO write, WO read, RO read of hardware status
    apb_xfer(0, 1'b1, 8'h0C, 32'h1122_3344, 4'hF, cyc, rd, err);
    check("wr_ro_err", 32'(err), 32'd1);
    check("wr_ro_pulse", 32'(wr_pulse0), 32'h00);
    apb_xfer(0, 1'b1, 8'h04, 32'h0000_0055, 4'hF, cyc, rd, err);
    check("wr_wo_err", 32'(err), 32'd0);
    exp0[1*32 +: 32] = 32'h0000_0055;
    check("wr_wo_pulse", 32'(wr_pulse0), 32'h02);
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, cyc, rd, err);
    check("rd_wo_err", 32'(err), 32'd1);
    check("rd_wo_data", rd, 32'd0);
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'hF, cyc, rd, err);
    check("rd_ro_err", 32'(err), 32'd0);
    check("rd_ro_data", rd, 32'hDEAD_BEEF);
    check_regs("prot_ctl", hw_ctl0, exp0);

    // Decode errors: out of range and misaligned
    apb_xfer(0, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, cyc, rd, err);
    check("oor_wr_err", 32'(err), 32'd1);
    check("oor_wr_pulse", 32'(wr_pulse0), 32'h00);
    apb_xfer(0, 1'b0, 8'h02, 32'h0, 4'hF, cyc, rd, err);
    check("mis_rd_err", 32'(err), 32'd1);
    check("mis_rd_data", rd, 32'd0);
    apb_xfer(0, 1'b1, 8'h02, 32'hFFFF_FFFF, 4'hF, cyc, rd, err);
    check("mis_wr_err", 32'(err), 32'd1);
    check("mis_wr_pulse", 32'(wr_pulse0), 32'h00);
    check_regs("dec_ctl", hw_ctl0, exp0);

    // W1C: hardware set, clear racing a set, plain clear
    @(posedge pclk); #1;
    hw_set[2*32 +: 32] = 32'h0000_0011;
    @(posedge pclk); #1;
    hw_set = '0;
    check("w1c_set", hw_ctl0[2*32 +: 32], 32'h0000_0011);
    hw_set[2*32 +: 32] = 32'h0000_0001;
    apb_xfer(0, 1'b1, 8'h08, 32'h0000_0001, 4'hF, cyc, rd, err);
    hw_set = '0;
    check("w1c_race", hw_ctl0[2*32 +: 32], 32'h0000_0011);
    apb_xfer(0, 1'b1, 8'h08, 32'h0000_0010, 4'hF, cyc, rd, err);
    check("w1c_clr", hw_ctl0[2*32 +: 32], 32'h0000_0001);
    apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, cyc, rd, err);
    check("w1c_rd", rd, 32'h0000_0001);

    // Write wait states on the second instance
    apb_xfer(1, 1'b1, 8'h14, 32'hCAFE_F00D, 4'hF, cyc, rd, err);
    check("ws_cycles", 32'(cyc), 32'd5);
    check("ws_err", 32'(err), 32'd0);
    check("ws_ctl", hw_ctl1[5*32 +: 32], 32'hCAFE_F00D);
    check("ws_pulse", 32'(wr_pulse1), 32'h20);

    // Abort: psel dropped in cycle 3 of a waited write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h0BAD_BEEF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort_c2_ready", 32'(pready1), 32'd0);
    check("abort_c2_rdata", prdata1, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("abort_c3_ready", 32'(pready1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      check("abort_pulse", 32'(wr_pulse1), 32'h00);
    end
    check("abort_ctl", hw_ctl1[6*32 +: 32], 32'd0);
    apb_xfer(1, 1'b1, 8'h18, 32'h0BAD_BEEF, 4'hF, cyc, rd, err);
    check("post_abort_cycles", 32'(cyc), 32'd5);
    check("post_abort_ctl", hw_ctl1[6*32 +: 32], 32'h0BAD_BEEF);

    // Asynchronous reset while a read is completing
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("prerst_ready", 32'(pready0), 32'd1);
    check("prerst_data", prdata0, 32'h00BB_00DD);
    #2 preset = 1'b1;
    #1;
    check("arst_ready", 32'(pready0), 32'd0);
    check("arst_pslverr", 32'(pslverr0), 32'd0);
    check("arst_prdata", prdata0, 32'd0);
    check("arst_pulse", 32'(wr_pulse0), 32'h00);
    check_regs("arst_ctl0", hw_ctl0, '0);
    #11;
    psel = 1'b0; penable = 1'b0;
    preset = 1'b0;
    @(posedge pclk); #1;
    check_regs("post_rst_ctl0", hw_ctl0, '0);
    check_regs("post_rst_ctl1", hw_ctl1, '0);
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, cyc, rd, err);
    check("post_rst_rd_cycles", 32'(cyc), 32'd3);
    check("post_rst_rd_data", rd, 32'd0);
    check("post_rst_rd_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
